// File: rtl/spike_event_scheduler.sv
// Queues spike axon indices and walks all target neurons per spike, adding each signed synapse weight into the neuron current field.
// Latency: first writeback 2 cycles after acceptance, then 1 neuron/cycle; spike_ready drops only when the FIFO is full; memories never stall.
module spike_event_scheduler #(
    parameter int NR_WIDTH     = 56,
    parameter int NR_I_WIDTH   = 16,
    parameter int SR_SYN_WIDTH = 4,
    parameter int N_NEURONS    = 16,
    parameter int AXON_WIDTH   = 4,
    parameter int FIFO_DEPTH   = 4,
    localparam int NIDX        = $clog2(N_NEURONS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spike_valid,
    input  logic [AXON_WIDTH-1:0]      spike_axon,
    output logic                       spike_ready,
    output logic                       syn_rd_en,
    output logic [AXON_WIDTH+NIDX-1:0] syn_rd_addr,
    input  logic [SR_SYN_WIDTH-1:0]    syn_rd_data,
    output logic                       nr_rd_en,
    output logic [NIDX-1:0]            nr_rd_addr,
    input  logic [NR_WIDTH-1:0]        nr_rd_data,
    output logic                       nr_wr_en,
    output logic [NIDX-1:0]            nr_wr_addr,
    output logic [NR_WIDTH-1:0]        nr_wr_data,
    output logic                       busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t                  state_q, state_d;
    logic [NIDX-1:0]         n_q, n_d;
    logic [AXON_WIDTH-1:0]   cur_axon_q, cur_axon_d;
    logic [AXON_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AXON_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    wb_vld_q, wb_vld_d;
    logic [NIDX-1:0]         wb_idx_q, wb_idx_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [NR_I_WIDTH-1:0]   weight_ext;
    logic [NR_I_WIDTH-1:0]   i_new;

    assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign spike_ready = !fifo_full;
    // A full FIFO refuses the push even if the FSM pops on the same edge.
    assign push        = spike_valid && !fifo_full;
    assign busy        = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cur_axon_d  = cur_axon_q;
        pop         = 1'b0;
        syn_rd_en   = 1'b0;
        nr_rd_en    = 1'b0;
        syn_rd_addr = '0;
        nr_rd_addr  = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_axon_d = fifo_mem_q[rd_ptr_q];
                    n_d        = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                syn_rd_en   = 1'b1;
                nr_rd_en    = 1'b1;
                syn_rd_addr = {cur_axon_q, n_q};
                nr_rd_addr  = n_q;
                n_d         = n_q + NIDX'(1);
                if (n_q == NIDX'(N_NEURONS - 1)) begin
                    // Chain straight into the next queued spike without a bubble.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        cur_axon_d = fifo_mem_q[rd_ptr_q];
                        n_d        = '0;
                    end else begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = spike_axon;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        wb_vld_d = (state_q == RUN);
        wb_idx_d = n_q;
    end

    // Read data arrives one cycle after the read; the add wraps modulo 2^NR_I_WIDTH.
    assign weight_ext = {{(NR_I_WIDTH - SR_SYN_WIDTH){syn_rd_data[SR_SYN_WIDTH-1]}}, syn_rd_data};
    assign i_new      = nr_rd_data[NR_I_WIDTH-1:0] + weight_ext;
    assign nr_wr_en   = wb_vld_q && (syn_rd_data != '0);
    assign nr_wr_addr = wb_idx_q;
    assign nr_wr_data = wb_vld_q ? {nr_rd_data[NR_WIDTH-1:NR_I_WIDTH], i_new} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cur_axon_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_vld_q   <= 1'b0;
            wb_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cur_axon_q <= cur_axon_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_vld_q   <= wb_vld_d;
            wb_idx_q   <= wb_idx_d;
        end
    end

endmodule

// File: doc/spike_event_scheduler.md
# spike_event_scheduler

Sequences synaptic integration for one neuron core. Accepts presynaptic spike events (axon indices) into a small FIFO. For each event, walks all target neurons, reads the signed synapse weight and the neuron state word, and adds the weight into the neuron's current field. It then writes the state back. Throughput is one neuron per cycle, and the block sits between the spike router and the neuron/synapse state memories.

## Interface
- NR_WIDTH, 56, neuron state word width
- NR_I_WIDTH, 16, width of current field I, stored in state bits [NR_I_WIDTH-1:0]
- SR_SYN_WIDTH, 4, signed synapse weight width
- N_NEURONS, 16, target neurons per axon; power of two, >= 2
- AXON_WIDTH, 4, axon index width
- FIFO_DEPTH, 4, spike FIFO entries; power of two, >= 2
- NIDX = $clog2(N_NEURONS) (derived)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- spike_valid  in  1  spike event offered
- spike_axon  in  AXON_WIDTH  presynaptic axon index
- spike_ready  out  1  FIFO can accept (= not full)
- syn_rd_en  out  1  synapse memory read strobe
- syn_rd_addr  out  AXON_WIDTH+NIDX  {axon, neuron index}
- syn_rd_data  in  SR_SYN_WIDTH  weight, valid one cycle after syn_rd_en
- nr_rd_en  out  1  neuron memory read strobe
- nr_rd_addr  out  NIDX  neuron index
- nr_rd_data  in  NR_WIDTH  state, valid one cycle after nr_rd_en
- nr_wr_en  out  1  neuron memory write strobe
- nr_wr_addr  out  NIDX  writeback index
- nr_wr_data  out  NR_WIDTH  updated state
- busy  out  1  high unless FSM is IDLE and FIFO is empty

## Operation
- Handshake: a spike is pushed on a rising edge when spike_valid && spike_ready. spike_ready = (count != FIFO_DEPTH). The spike source may hold valid; there is no backpressure on the memories.
- FIFO: circular with wrapping pointers and a count from 0 to FIFO_DEPTH. A push and a pop on the same edge leave the count unchanged. When the FIFO is full, no push is accepted, even if a pop occurs on the same edge.
- FSM states: IDLE, RUN, TAIL.
  - IDLE -> RUN when the FIFO is non-empty: pop the head into cur_axon and set n=0.
  - RUN: assert syn_rd_en/nr_rd_en with addresses {cur_axon,n} and n. Increment n each cycle.
  - RUN at n==N_NEURONS-1: if the FIFO is non-empty, pop, load the new cur_axon, set n=0 and stay in RUN with no bubble. Otherwise go to TAIL.
  - TAIL: perform the final writeback only, then go to IDLE.
- Writeback stage, one cycle after each read: a registered valid and index delay the read address.
  - I_new = I_old + sign_extend(weight), computed modulo 2^NR_I_WIDTH (two's-complement wrap, no saturation).
  - State bits [NR_WIDTH-1:NR_I_WIDTH] pass through unchanged.
  - nr_wr_data = {upper, I_new} and nr_wr_addr = delayed index.
  - nr_wr_en = delayed valid && (weight != 0). Zero weights suppress the write.
- Hazards: the read address differs from the in-flight writeback address in every cycle, because N_NEURONS >= 2. No forwarding is needed.
- Async reset mid-operation:
  - FSM goes to IDLE, the FIFO empties and pending writebacks are dropped.
  - Read/write enables go low immediately.
  - Memory contents are not restored.

## Timing
- Reset values:
  - spike_ready=1; busy=0.
  - syn_rd_en, nr_rd_en and nr_wr_en = 0.
  - All address and data outputs = 0.
- Spike accepted at edge E0 while IDLE:
  - E1 enters RUN, and the read of neuron 0 is issued in cycle E1..E2.
  - The write of neuron 0 occurs in cycle E2..E3.
  - The write of neuron N-1 occurs in cycle E(N+1)..E(N+2), and the FSM is back in IDLE at E(N+2).
- Latency from acceptance to first write is 2 cycles. Back-to-back queued spikes sustain 1 neuron/cycle, N_NEURONS cycles per spike.
- busy is combinational from state and count. It rises in the cycle after E0 and falls in the cycle after the last writeback.
- Read enables and addresses are combinational from state/n. Write outputs come from registered stage signals plus combinational add.

## Test plan
- Single spike, axon 3, weights for n=0..15 = +1, with nr mem I=0x0005 and upper bits 0xAB_CDEF_0123 -> 16 writes, each I=0x0006, upper bits unchanged; first write 2 cycles after acceptance; busy low after N+2 cycles.
- Wrap: I=0x7FFF with weight +7 -> 0x8006. I=0x0000 with weight -8 (4'b1000) -> 0xFFF8. I=0xFFFF with weight +1 -> 0x0000.
- Zero-weight skip: weights alternate 0/+2 -> exactly 8 writes, only to odd neurons; even-neuron state is untouched.
- FIFO full: hold spike_valid with 6 distinct axons while the FSM runs.
  - spike_ready deasserts once 4 entries are queued.
  - All accepted spikes are processed in order with no idle cycle between them.
  - No spike is lost or duplicated.
- Reset mid-run: assert rst_n=0 at n=7 of a spike with 2 more queued.
  - All enables drop in the same cycle, and busy=0.
  - After release, spike_ready=1, no further writes occur, and a new spike is processed normally.
